// File: rtl/multi_hex_disp_scan.sv
// Multiplexed hex display scanner: prescaled digit scan, shadow/active value
// registers swapped at frame boundaries, hex-to-7-segment decode with optional
// leading-zero blanking, registered outputs with selectable polarity.
// Latency: outputs follow the digit index / active register by one cycle.
// Backpressure: none; i_Load is a strobe and is always accepted (latest wins).
//
// Ports:
//   i_Clk, i_Rst      clock, asynchronous active-high reset
//   i_Load            strobe capturing i_Value / i_Dp
//   i_Value, i_Dp     nibble per digit (digit 0 in LSBs), decimal point per digit
//   i_Blank           forces segments, Dp and digit enables inactive
//   o_Segments        A..G on bits 6..0
//   o_Dp, o_Digit_En  decimal point of the driven digit, one-hot digit enable
//   o_Pending         a loaded value is waiting for the next frame boundary
//   o_Frame_Done      one-cycle pulse after each frame wrap
module multi_hex_disp_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 25000,
  parameter int ACTIVE_LOW     = 0,
  parameter int BLANK_LZ       = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic [NUM_DIGITS-1:0]   i_Dp,
  input  logic                    i_Blank,
  output logic [6:0]              o_Segments,
  output logic                    o_Dp,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic                    o_Pending,
  output logic                    o_Frame_Done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_CYCLES);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_CYCLES - 1);
  localparam logic          POL      = (ACTIVE_LOW != 0);

  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         active_q, active_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] dp_act_q, dp_act_d;
  logic [NUM_DIGITS-1:0] dp_sh_q, dp_sh_d;
  logic                  pend_q, pend_d;
  logic                  fdone_q;
  logic [6:0]            seg_q, seg_d;
  logic                  dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;

  logic                  tc;
  logic                  wrap;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
    endcase
    return s;
  endfunction

  // Scan sequencing and shadow/active hand-over.
  always_comb begin
    tc       = (pre_q == PRE_LAST);
    wrap     = tc && (idx_q == IDX_LAST);
    pre_d    = tc ? '0 : pre_q + PW'(1);
    idx_d    = idx_q;
    active_d = active_q;
    dp_act_d = dp_act_q;
    shadow_d = shadow_q;
    dp_sh_d  = dp_sh_q;
    pend_d   = pend_q;
    if (tc) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end
    if (wrap && i_Load) begin
      // Load on the boundary itself bypasses the shadow entirely.
      active_d = i_Value;
      dp_act_d = i_Dp;
      pend_d   = 1'b0;
    end else if (i_Load) begin
      shadow_d = i_Value;
      dp_sh_d  = i_Dp;
      pend_d   = 1'b1;
    end else if (wrap && pend_q) begin
      active_d = shadow_q;
      dp_act_d = dp_sh_q;
      pend_d   = 1'b0;
    end
  end

  // Output decode from the current index and active value.
  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  lz_sel;
  logic [NUM_DIGITS-1:0] lz;
  logic                  all_zero;
  logic [6:0]            seg_raw;

  always_comb begin
    // lz[k]: nibble k and every more-significant nibble are zero.
    all_zero = 1'b1;
    lz       = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero & (active_q[4*k +: 4] == 4'h0);
      lz[k]    = all_zero;
    end
    nib    = '0;
    dp_sel = 1'b0;
    lz_sel = 1'b0;
    en_d   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib     = active_q[4*k +: 4];
        dp_sel  = dp_act_q[k];
        lz_sel  = (k != 0) && lz[k];
        en_d[k] = 1'b1;
      end
    end
    seg_raw = ((BLANK_LZ != 0) && lz_sel) ? 7'h00 : hex7(nib);
    dpo_d   = dp_sel;
    if (i_Blank) begin
      seg_raw = 7'h00;
      dpo_d   = 1'b0;
      en_d    = '0;
    end
    seg_d = seg_raw ^ {7{POL}};
    dpo_d = dpo_d ^ POL;
    en_d  = en_d ^ {NUM_DIGITS{POL}};
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      pre_q    <= '0;
      idx_q    <= '0;
      active_q <= '0;
      shadow_q <= '0;
      dp_act_q <= '0;
      dp_sh_q  <= '0;
      pend_q   <= 1'b0;
      fdone_q  <= 1'b0;
      seg_q    <= {7{POL}};
      dpo_q    <= POL;
      en_q     <= {NUM_DIGITS{POL}};
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      dp_act_q <= dp_act_d;
      dp_sh_q  <= dp_sh_d;
      pend_q   <= pend_d;
      fdone_q  <= wrap;
      seg_q    <= seg_d;
      dpo_q    <= dpo_d;
      en_q     <= en_d;
    end
  end

  assign o_Segments   = seg_q;
  assign o_Dp         = dpo_q;
  assign o_Digit_En   = en_q;
  assign o_Pending    = pend_q;
  assign o_Frame_Done = fdone_q;

endmodule

// File: tb/tb_multi_hex_disp_scan.sv
module tb_multi_hex_disp_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank = 1'b0;

  logic [6:0]  seg, seg_al;
  logic        dp, dp_al;
  logic [3:0]  en, en_al;
  logic        pend, pend_al;
  logic        fd, fd_al;

  int n_vec = 0;
  int n_err = 0;
  int c = 0;

  always #20 clk = ~clk;

  multi_hex_disp_scan #(.NUM_DIGITS(4), .REFRESH_CYCLES(4), .ACTIVE_LOW(0), .BLANK_LZ(1)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Load(load), .i_Value(value), .i_Dp(dp_in), .i_Blank(blank),
    .o_Segments(seg), .o_Dp(dp), .o_Digit_En(en), .o_Pending(pend), .o_Frame_Done(fd)
  );

  multi_hex_disp_scan #(.NUM_DIGITS(4), .REFRESH_CYCLES(4), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut_al (
    .i_Clk(clk), .i_Rst(rst), .i_Load(load), .i_Value(value), .i_Dp(dp_in), .i_Blank(blank),
    .o_Segments(seg_al), .o_Dp(dp_al), .o_Digit_En(en_al), .o_Pending(pend_al), .o_Frame_Done(fd_al)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @c=%0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  // Edges are counted from reset release; checks and input changes happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic run_to(input int t);
    while (c < t) tick();
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic disp(input string tag, input logic [3:0] e, input logic [6:0] s);
    chk({tag, "_en"}, en, e);
    chk({tag, "_seg"}, seg, s);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_seg", seg, 7'h00);
    chk("rst_dp", dp, 1'b0);
    chk("rst_en", en, 4'h0);
    chk("rst_pend", pend, 1'b0);
    chk("rst_fd", fd, 1'b0);
    chk("rst_al_seg", seg_al, 7'h7F);
    chk("rst_al_dp", dp_al, 1'b1);
    chk("rst_al_en", en_al, 4'hF);

    // Scan order and frame pulse over two frames
    rst = 1'b0;
    c = 0;
    for (int n = 1; n <= 32; n++) begin
      tick();
      chk("scan_en", en, 4'b0001 << (((n - 1) / 4) % 4));
      chk("frame_done", fd, (n % 16) == 0);
      if (n == 1) chk("first_seg", seg, 7'h7E);
      if (n == 5) chk("lz_zero_seg", seg, 7'h00);
    end

    // Mid-frame load waits for the wrap
    run_to(36);
    load_val(16'h12AF, 4'b0010);
    chk("b_pend_set", pend, 1'b1);
    run_to(47);
    chk("b_pend_hold", pend, 1'b1);
    disp("b_old", 4'b1000, 7'h00);
    run_to(48);
    chk("b_pend_clr", pend, 1'b0);
    chk("b_fd", fd, 1'b1);
    run_to(49); disp("b_d0", 4'b0001, 7'h47); chk("b_d0_dp", dp, 1'b0);
    run_to(53); disp("b_d1", 4'b0010, 7'h77); chk("b_d1_dp", dp, 1'b1);
    run_to(57); disp("b_d2", 4'b0100, 7'h6D);
    run_to(61); disp("b_d3", 4'b1000, 7'h30);

    // Leading-zero blanking, Dp unaffected
    run_to(66);
    load_val(16'h0005, 4'b1000);
    run_to(81); disp("c_d0", 4'b0001, 7'h5B);
    run_to(85); disp("c_d1", 4'b0010, 7'h00); chk("c_d1_dp", dp, 1'b0);
    run_to(89); disp("c_d2", 4'b0100, 7'h00);
    run_to(93); disp("c_d3", 4'b1000, 7'h00); chk("c_d3_dp", dp, 1'b1);
    run_to(94);
    load_val(16'h0000, 4'b0000);
    run_to(97);  disp("z_d0", 4'b0001, 7'h7E);
    run_to(101); disp("z_d1", 4'b0010, 7'h00);
    run_to(109); disp("z_d3", 4'b1000, 7'h00);

    // Load coinciding with the wrap goes straight to active
    run_to(111);
    load_val(16'h8888, 4'b0000);
    chk("d_wrap_pend", pend, 1'b0);
    chk("d_wrap_fd", fd, 1'b1);
    run_to(113); disp("d_d0", 4'b0001, 7'h7F); chk("d_pend", pend, 1'b0);
    run_to(114);
    load_val(16'h1111, 4'b0000);
    chk("d_pend1", pend, 1'b1);
    run_to(117); disp("d_d1", 4'b0010, 7'h7F);
    run_to(120);
    load_val(16'h0033, 4'b0000);
    chk("d_pend2", pend, 1'b1);
    run_to(127); disp("d_d3_old", 4'b1000, 7'h7F);
    run_to(128); chk("d_pend_clr", pend, 1'b0);
    run_to(129); disp("d2_d0", 4'b0001, 7'h79);
    run_to(133); disp("d2_d1", 4'b0010, 7'h79);
    run_to(137); disp("d2_d2", 4'b0100, 7'h00);

    // Blank, both polarities
    run_to(138);
    blank = 1'b1;
    tick();
    disp("e_main", 4'h0, 7'h00);
    chk("e_main_dp", dp, 1'b0);
    chk("e_al_seg", seg_al, 7'h7F);
    chk("e_al_dp", dp_al, 1'b1);
    chk("e_al_en", en_al, 4'hF);
    run_to(144);
    chk("e_fd", fd, 1'b1);
    chk("e_al_fd", fd_al, 1'b1);
    chk("e_al_en2", en_al, 4'hF);
    blank = 1'b0;
    tick();
    disp("e_unblank", 4'b0001, 7'h79);
    chk("e_al_seg_inv", seg_al, 7'h06);
    chk("e_al_en_inv", en_al, 4'b1110);
    chk("e_al_dp_inv", dp_al, 1'b1);

    // Reset while pending discards the shadow
    run_to(150);
    load_val(16'h4567, 4'b1111);
    chk("f_pend", pend, 1'b1);
    rst = 1'b1;
    #1;
    chk("f_rst_seg", seg, 7'h00);
    chk("f_rst_en", en, 4'h0);
    chk("f_rst_pend", pend, 1'b0);
    chk("f_rst_al_seg", seg_al, 7'h7F);
    chk("f_rst_al_en", en_al, 4'hF);
    tick(); tick();
    rst = 1'b0;
    c = 0;
    tick();
    disp("f_rel", 4'b0001, 7'h7E);
    chk("f_rel_pend", pend, 1'b0);
    run_to(16);
    chk("f_fd", fd, 1'b1);
    run_to(17);
    disp("f_after_wrap", 4'b0001, 7'h7E);
    chk("f_after_dp", dp, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
